// File: rtl/decision_scan_mux_if.sv
// Handshake bundle for decision_scan_mux. The master drives mode, select, data and ready.
// The slave returns the registered decision, its channel and valid.
interface decision_scan_mux_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic                      Mode;
  logic [SEL_W-1:0]          Select;
  logic [CHANNELS*WIDTH-1:0] Data;
  logic                      Ready;
  logic [WIDTH-1:0]          Decision;
  logic [SEL_W-1:0]          Channel;
  logic                      Valid;

  modport master (
    output Mode, Select, Data, Ready,
    input  Decision, Channel, Valid
  );

  modport slave (
    input  Mode, Select, Data, Ready,
    output Decision, Channel, Valid
  );
endinterface

// File: rtl/decision_scan_mux.sv
// Registered channel selector with manual select, or a timed scan behind a one-entry valid/ready output.
// Define DECISION_SKIP_ZERO_EN to make the scan skip channels whose value is zero.
//
// state      | meaning
// MANUAL     | output follows Select; every free slot captures a new sample
// SCAN_EMIT  | scanned sample is held until downstream consumes it
// SCAN_DWELL | dwell counter runs; at terminal count the next channel is captured
module decision_scan_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 1024
) (
  input logic                Clk,
  input logic                Rst_n,
  decision_scan_mux_if.slave bus
);
  localparam int CNT_W = $clog2(DWELL) + 1;

  typedef enum logic [1:0] {MANUAL, SCAN_EMIT, SCAN_DWELL} state_t;

  state_t           state, state_nx;
  logic [SEL_W-1:0] ptr, ptr_nx, chan, chan_nx;
  logic [SEL_W-1:0] adv_ptr, scan_start, pick_ptr;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] dec, dec_nx, sel_val, pick_val;
  logic             valid, valid_nx, pick_ok, consume;

  // Indices at or beyond CHANNELS read as zero.
  function automatic logic [WIDTH-1:0] slice_of(input logic [CHANNELS*WIDTH-1:0] d,
                                                input logic [SEL_W-1:0] idx);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (idx == SEL_W'(k)) v = d[k*WIDTH +: WIDTH];
    return v;
  endfunction

  assign consume    = valid & bus.Ready;
  assign adv_ptr    = (ptr == SEL_W'(CHANNELS - 1)) ? '0 : ptr + SEL_W'(1);
  assign scan_start = (state == MANUAL) ? '0 : adv_ptr;
  assign sel_val    = slice_of(bus.Data, bus.Select);
  assign pick_val   = slice_of(bus.Data, pick_ptr);

`ifdef DECISION_SKIP_ZERO_EN
  // Walk backwards so the nearest nonzero channel after scan_start wins.
  always_comb begin
    pick_ok  = 1'b0;
    pick_ptr = ptr;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (slice_of(bus.Data, SEL_W'((int'(scan_start) + i) % CHANNELS)) != '0) begin
        pick_ok  = 1'b1;
        pick_ptr = SEL_W'((int'(scan_start) + i) % CHANNELS);
      end
    end
  end
`else
  assign pick_ok  = 1'b1;
  assign pick_ptr = scan_start;
`endif

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    dec_nx   = dec;
    chan_nx  = chan;
    valid_nx = valid;
    case (state)
      MANUAL: begin
        if (bus.Mode) begin
          cnt_nx   = '0;
          valid_nx = 1'b0;
          state_nx = SCAN_DWELL;
          if (pick_ok) begin
            ptr_nx   = pick_ptr;
            dec_nx   = pick_val;
            chan_nx  = pick_ptr;
            valid_nx = 1'b1;
            state_nx = SCAN_EMIT;
          end
        end else if (!valid || bus.Ready) begin
          dec_nx   = sel_val;
          chan_nx  = bus.Select;
          valid_nx = 1'b1;
        end
      end
      SCAN_EMIT: begin
        if (!bus.Mode) begin
          valid_nx = 1'b0;
          state_nx = MANUAL;
        end else if (consume) begin
          valid_nx = 1'b0;
          cnt_nx   = '0;
          state_nx = SCAN_DWELL;
        end
      end
      SCAN_DWELL: begin
        if (!bus.Mode) begin
          valid_nx = 1'b0;
          state_nx = MANUAL;
        end else if (cnt == CNT_W'(DWELL - 1)) begin
          // With nothing to capture the dwell simply restarts.
          cnt_nx = '0;
          if (pick_ok) begin
            ptr_nx   = pick_ptr;
            dec_nx   = pick_val;
            chan_nx  = pick_ptr;
            valid_nx = 1'b1;
            state_nx = SCAN_EMIT;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        valid_nx = 1'b0;
        state_nx = MANUAL;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= MANUAL;
      ptr   <= '0;
      cnt   <= '0;
      dec   <= '0;
      chan  <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
      dec   <= dec_nx;
      chan  <= chan_nx;
      valid <= valid_nx;
    end
  end

  assign bus.Decision = dec;
  assign bus.Channel  = chan;
  assign bus.Valid    = valid;
endmodule

// File: tb/tb_decision_scan_mux.sv
// Bench for decision_scan_mux: directed scenarios plus random traffic against a cycle-level reference model.
// A second three-channel instance covers out-of-range manual selects.
module tb_decision_scan_mux;
  localparam int WIDTH    = 4;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;
  localparam int DWELL    = 3;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  decision_scan_mux_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus ();
  decision_scan_mux_if #(.WIDTH(WIDTH), .CHANNELS(3), .SEL_W(SEL_W)) bus3 ();

  assign bus3.Mode   = 1'b0;
  assign bus3.Select = bus.Select;
  assign bus3.Data   = bus.Data[11:0];
  assign bus3.Ready  = bus.Ready;

  decision_scan_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  decision_scan_mux #(.WIDTH(WIDTH), .CHANNELS(3), .SEL_W(SEL_W), .DWELL(DWELL)) dut3 (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus3)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: scanning flag, edges left in the dwell, current scan channel
  bit m_scan, m_valid, m3_valid;
  int m_left, m_ptr, m_dec, m_chan, m3_dec, m3_chan;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nib(input logic [15:0] d, input int k);
    return int'(d[k*WIDTH +: WIDTH]);
  endfunction

  function automatic int pick(input logic [15:0] d, input int start);
`ifdef DECISION_SKIP_ZERO_EN
    for (int i = 0; i < CHANNELS; i++)
      if (nib(d, (start + i) % CHANNELS) != 0) return (start + i) % CHANNELS;
    return -1;
`else
    return start % CHANNELS;
`endif
  endfunction

  task automatic model_capture(input int nx);
    m_left = DWELL;
    if (nx >= 0) begin
      m_ptr   = nx;
      m_dec   = nib(bus.Data, nx);
      m_chan  = nx;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic model_step();
    int sel;
    sel = int'(bus.Select);
    if (!Rst_n) begin
      m_scan = 0; m_valid = 0; m_left = 0; m_ptr = 0; m_dec = 0; m_chan = 0;
      m3_valid = 0; m3_dec = 0; m3_chan = 0;
      return;
    end
    if (!m3_valid || bus.Ready) begin
      m3_chan  = sel;
      m3_dec   = (sel < 3) ? nib(bus.Data, sel) : 0;
      m3_valid = 1'b1;
    end
    if (!bus.Mode) begin
      if (m_scan) begin
        m_scan  = 0;
        m_valid = 0;
      end else if (!m_valid || bus.Ready) begin
        m_dec   = nib(bus.Data, sel);
        m_chan  = sel;
        m_valid = 1'b1;
      end
    end else if (!m_scan) begin
      m_scan = 1;
      model_capture(pick(bus.Data, 0));
    end else if (m_valid) begin
      if (bus.Ready) begin
        m_valid = 0;
        m_left  = DWELL;
      end
    end else begin
      m_left--;
      if (m_left == 0) model_capture(pick(bus.Data, (m_ptr + 1) % CHANNELS));
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    check_val("valid", bus.Valid, m_valid);
    check_val("decision", bus.Decision, m_dec);
    check_val("channel", bus.Channel, m_chan);
    check_val("dut3", {bus3.Valid, bus3.Channel, bus3.Decision}, m3_valid * 64 + m3_chan * 16 + m3_dec);
  endtask

  // Ticks until Valid is seen (at most lim edges); returns edges taken, or -1.
  task automatic wait_valid(input int lim, output int taken);
    taken = -1;
    for (int i = 1; i <= lim; i++) begin
      tick();
      if (bus.Valid === 1'b1) begin
        taken = i;
        break;
      end
    end
  endtask

  initial begin
    int idx [$];
    int decs [$];
    int t;

    bus.Mode = 0; bus.Select = 0; bus.Data = 16'h0; bus.Ready = 0;

    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      bus.Mode = 1'($urandom); bus.Select = SEL_W'($urandom);
      bus.Data = 16'($urandom); bus.Ready = 1'($urandom);
      tick();
      check_val("rst_out", {bus.Valid, bus.Channel, bus.Decision}, 0);
    end

    // manual mux
    Rst_n = 1; bus.Mode = 0; bus.Ready = 1; bus.Data = 16'h4321;
    for (int k = 0; k < 4; k++) begin
      bus.Select = SEL_W'(k);
      tick();
      check_val("man_dec", bus.Decision, k + 1);
      check_val("man_valid", bus.Valid, 1);
    end
    check_val("ch3_sel3_dec", bus3.Decision, 0);
    check_val("ch3_sel3_chan", bus3.Channel, 3);

    // scan with Ready held high
    bus.Mode = 1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (bus.Valid === 1'b1) begin
        idx.push_back(i);
        decs.push_back(int'(bus.Decision));
      end
    end
    check_val("scan_count", idx.size(), 5);
    for (int i = 0; i < idx.size() && i < 5; i++) begin
      check_val("scan_dec", decs[i], (i % 4) + 1);
      check_val("scan_time", idx[i], 1 + 4 * i);
    end

    // backpressure
    tick();
    wait_valid(10, t);
    check_val("bp_reach", t, DWELL);
    check_val("bp_first", bus.Decision, 2);
    bus.Ready = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("bp_hold", {bus.Valid, bus.Channel, bus.Decision}, {1'b1, 2'd1, 4'd2});
    end
    bus.Ready = 1;
    wait_valid(20, t);
    check_val("bp_period", t, DWELL + 1);
    check_val("bp_next", bus.Decision, 3);

    // mode exit colliding with consume
    bus.Mode = 0; bus.Select = 3;
    tick();
    check_val("exit_valid", bus.Valid, 0);
    check_val("exit_keep", bus.Decision, 3);
    tick();
    check_val("exit_manual", {bus.Valid, bus.Channel, bus.Decision}, {1'b1, 2'd3, 4'd4});

    // reset in SCAN_EMIT under backpressure
    bus.Mode = 1;
    tick();
    bus.Ready = 0; Rst_n = 0;
    tick();
    check_val("rst_scan", {bus.Valid, bus.Decision}, 0);
    Rst_n = 1; bus.Mode = 0; bus.Select = 1;
    tick();
    check_val("rst_manual", {bus.Valid, bus.Decision}, {1'b1, 4'd2});

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] d;
      for (int k = 0; k < 4; k++)
        d[k*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 15) == 0) bus.Mode = ~bus.Mode;
      if ($urandom_range(0, 3) == 0) bus.Data = d;
      bus.Select = SEL_W'($urandom);
      bus.Ready  = ($urandom_range(0, 2) != 0);
      Rst_n      = ($urandom_range(0, 199) != 0);
      tick();
    end

`ifdef DECISION_SKIP_ZERO_EN
    Rst_n = 1; bus.Mode = 0; bus.Ready = 1; bus.Data = 16'h4020;
    tick();
    bus.Mode = 1;
    decs.delete();
    for (int i = 0; i < 40 && decs.size() < 4; i++) begin
      tick();
      if (bus.Valid === 1'b1) decs.push_back(int'(bus.Decision));
    end
    check_val("skip_count", decs.size(), 4);
    for (int i = 0; i < decs.size(); i++)
      check_val("skip_dec", decs[i], (i % 2 == 0) ? 2 : 4);
    bus.Mode = 0;
    tick();
    bus.Data = 16'h0000; bus.Mode = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      check_val("skip_allzero", bus.Valid, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
